regfile_write_arbiter: RTL and testbench

- Shares the single rD write port of the 8×16 register file between two writeback requesters:
  - Port A: ALU result path.
  - Port B: load/memory path.
- Round-robin arbitration with valid/ready handshakes.
- Accepted writes are registered onto the register-file write-port signals.
- Optional pending-write scoreboard lets the issue stage stall on registers with outstanding writes.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_write_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// regfile_write_arbiter
// ----------------------------------------------------------------------------
// Shares the single rD write port of the 8 x 16 register file between two
// writeback requesters:
//   - requester A : ALU result path
//   - requester B : load / memory path
// Arbitration is round-robin with valid/ready handshakes. An accepted write is
// registered onto the O_rD_* write-port signals one cycle after acceptance.
//
// Optional feature (compile-time macro REGFILE_ARB_SCOREBOARD_EN):
//   A pending-write scoreboard. The issue stage reserves a destination with
//   I_resv_valid/I_resv_sel and the matching bit of O_pending stays high until
//   the write to that register has been presented to the register file.
//   Without the macro, O_pending is tied to zero, the reservation inputs are
//   ignored and no scoreboard flops exist.
//
// Ports:
//   I_clk            clock, all state updates on the rising edge
//   I_reset_n        synchronous reset, active low
//   I_rf_enable      register file enabled this cycle; no grant while low
//   I_a_valid        requester A has a write
//   I_a_sel  [2:0]   A destination register
//   I_a_data [15:0]  A write data
//   I_a_pos  [1:0]   A write position (0 word, 1 low byte, 2 high byte, 3 no-op)
//   O_a_ready        A accepted this cycle (combinational)
//   I_b_*, O_b_ready same as A, for requester B
//   I_resv_valid     issue stage reserves a destination register
//   I_resv_sel [2:0] register being reserved
//   O_rD_write       write strobe to the register file (registered)
//   O_rD_select[2:0] write destination (registered)
//   O_rD_in   [15:0] write data (registered)
//   O_rD_write_pos[1:0] write position (registered)
//   O_pending [7:0]  bit i = register i has a reserved write not yet completed
// ============================================================================
module regfile_write_arbiter (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_rf_enable,

    input  logic        I_a_valid,
    input  logic [2:0]  I_a_sel,
    input  logic [15:0] I_a_data,
    input  logic [1:0]  I_a_pos,
    output logic        O_a_ready,

    input  logic        I_b_valid,
    input  logic [2:0]  I_b_sel,
    input  logic [15:0] I_b_data,
    input  logic [1:0]  I_b_pos,
    output logic        O_b_ready,

    input  logic        I_resv_valid,
    input  logic [2:0]  I_resv_sel,

    output logic        O_rD_write,
    output logic [2:0]  O_rD_select,
    output logic [15:0] O_rD_in,
    output logic [1:0]  O_rD_write_pos,
    output logic [7:0]  O_pending
);

    // Write position code meaning "transfer completes but nothing is written".
    localparam logic [1:0] POS_NOP = 2'd3;

    // Which requester is favoured when both ask in the same cycle.
    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t       prio_q;
    prio_t       prio_next;

    logic        arb_open;
    logic        grant_a;
    logic        grant_b;
    logic        xfer;

    logic [2:0]  win_sel;
    logic [15:0] win_data;
    logic [1:0]  win_pos;

    logic        rd_write_q;
    logic [2:0]  rd_select_q;
    logic [15:0] rd_in_q;
    logic [1:0]  rd_pos_q;

    // Nothing may be granted while reset is asserted or the register file is
    // disabled; a held request simply waits until both conditions clear.
    assign arb_open = I_reset_n & I_rf_enable;

    // Grant decision. A lone requester always wins; when both ask, the
    // priority pointer picks the winner. At most one grant per cycle.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (arb_open) begin
            if (I_a_valid && I_b_valid) begin
                if (prio_q == PRIO_A) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else if (I_a_valid) begin
                grant_a = 1'b1;
            end else if (I_b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign O_a_ready = grant_a;
    assign O_b_ready = grant_b;
    assign xfer      = grant_a | grant_b;

    // Payload of whichever requester won this cycle. When nobody wins the
    // values are don't-care because the output registers hold instead.
    always_comb begin
        win_sel  = I_a_sel;
        win_data = I_a_data;
        win_pos  = I_a_pos;
        if (grant_b) begin
            win_sel  = I_b_sel;
            win_data = I_b_data;
            win_pos  = I_b_pos;
        end
    end

    // Priority pointer update. After any grant the pointer moves to the port
    // that did not win, which covers both the contended case (flip to the
    // loser) and the uncontended case (point at the other port).
    always_comb begin
        prio_next = prio_q;
        if (grant_a) begin
            prio_next = PRIO_B;
        end else if (grant_b) begin
            prio_next = PRIO_A;
        end
    end

    // Priority pointer register; reset favours requester A.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            prio_q <= PRIO_A;
        end else begin
            prio_q <= prio_next;
        end
    end

    // Register-file write-port registers. An accepted transfer is captured
    // here and presented for exactly one cycle; a no-op position captures the
    // payload but leaves the strobe low. Reset also discards a write that was
    // captured but not yet performed.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            rd_write_q  <= 1'b0;
            rd_select_q <= 3'd0;
            rd_in_q     <= 16'h0000;
            rd_pos_q    <= 2'd0;
        end else if (xfer) begin
            rd_write_q  <= (win_pos != POS_NOP);
            rd_select_q <= win_sel;
            rd_in_q     <= win_data;
            rd_pos_q    <= win_pos;
        end else begin
            rd_write_q  <= 1'b0;
        end
    end

    assign O_rD_write     = rd_write_q;
    assign O_rD_select    = rd_select_q;
    assign O_rD_in        = rd_in_q;
    assign O_rD_write_pos = rd_pos_q;

`ifdef REGFILE_ARB_SCOREBOARD_EN

    logic [7:0] pending_q;
    logic [7:0] pending_next;
    logic [7:0] set_mask;
    logic [7:0] clear_mask;
    logic       done_q;

    // One-hot decode of a register number.
    function automatic logic [7:0] decode_sel(input logic [2:0] sel);
        logic [7:0] mask;
        mask      = 8'h00;
        mask[sel] = 1'b1;
        return mask;
    endfunction

    // done_q marks that the O_rD_* registers hold a transfer being completed
    // this cycle. It is separate from the write strobe because a no-op
    // position completes a transfer without strobing.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= xfer;
        end
    end

    // Pending mask next value. The clear comes from the transfer currently on
    // the write port; the set is applied after the clear so a reservation on
    // the same edge keeps the bit outstanding.
    always_comb begin
        set_mask     = 8'h00;
        clear_mask   = 8'h00;
        if (I_resv_valid) begin
            set_mask = decode_sel(I_resv_sel);
        end
        if (done_q) begin
            clear_mask = decode_sel(rd_select_q);
        end
        pending_next = (pending_q & ~clear_mask) | set_mask;
    end

    // Pending mask register. Reservations are recorded even while the
    // register file is disabled.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            pending_q <= 8'h00;
        end else begin
            pending_q <= pending_next;
        end
    end

    assign O_pending = pending_q;

`else

    // Scoreboard not built: reservation inputs are intentionally unused.
    logic unused_resv;
    assign unused_resv = ^{I_resv_valid, I_resv_sel};

    assign O_pending = 8'h00;

`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// tb_regfile_write_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for regfile_write_arbiter. A behavioural model tracks
// the expected write port contents, the round-robin favourite and the pending
// mask; directed sequences are followed by randomized traffic in which each
// requester holds its payload until it is accepted.
// Honours REGFILE_ARB_SCOREBOARD_EN for the pending-mask expectations.
// ============================================================================
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        rf_en;
    logic        a_valid;
    logic [2:0]  a_sel;
    logic [15:0] a_data;
    logic [1:0]  a_pos;
    logic        a_ready;
    logic        b_valid;
    logic [2:0]  b_sel;
    logic [15:0] b_data;
    logic [1:0]  b_pos;
    logic        b_ready;
    logic        resv_valid;
    logic [2:0]  resv_sel;
    logic        rd_write;
    logic [2:0]  rd_select;
    logic [15:0] rd_in;
    logic [1:0]  rd_pos;
    logic [7:0]  pending;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Model state: what the write port should show, who is favoured next,
    // which registers are outstanding and which one completes at next edge.
    logic        m_wr;
    logic [2:0]  m_sel;
    logic [15:0] m_data;
    logic [1:0]  m_pos;
    bit          m_favour_b;
    logic [7:0]  m_pend;
    logic [7:0]  m_completing;

    logic        seen_a_ready;
    logic        seen_b_ready;

    regfile_write_arbiter dut (
        .I_clk          (clk),
        .I_reset_n      (rst_n),
        .I_rf_enable    (rf_en),
        .I_a_valid      (a_valid),
        .I_a_sel        (a_sel),
        .I_a_data       (a_data),
        .I_a_pos        (a_pos),
        .O_a_ready      (a_ready),
        .I_b_valid      (b_valid),
        .I_b_sel        (b_sel),
        .I_b_data       (b_data),
        .I_b_pos        (b_pos),
        .O_b_ready      (b_ready),
        .I_resv_valid   (resv_valid),
        .I_resv_sel     (resv_sel),
        .O_rD_write     (rd_write),
        .O_rD_select    (rd_select),
        .O_rD_in        (rd_in),
        .O_rD_write_pos (rd_pos),
        .O_pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs. Checks the
    // combinational handshake mid-cycle, advances the model at the edge and
    // checks the registered outputs just after it.
    task automatic applyStimulus();
        bit         want_a;
        bit         want_b;
        bit         win_a;
        bit         win_b;
        logic [7:0] reserve;
        #1;
        want_a = rst_n && rf_en && a_valid;
        want_b = rst_n && rf_en && b_valid;
        win_a  = want_a && !(want_b && m_favour_b);
        win_b  = want_b && !win_a;
        seen_a_ready = a_ready;
        seen_b_ready = b_ready;
        checkOutput("a_ready", a_ready, win_a);
        checkOutput("b_ready", b_ready, win_b);
        reserve = (SB && resv_valid) ? (8'b1 << resv_sel) : 8'h00;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_wr = 1'b0; m_sel = 3'd0; m_data = 16'h0; m_pos = 2'd0;
            m_favour_b = 1'b0; m_pend = 8'h00; m_completing = 8'h00;
        end else begin
            m_pend = (m_pend & ~m_completing) | reserve;
            m_completing = 8'h00;
            if (win_a || win_b) begin
                m_sel  = win_a ? a_sel  : b_sel;
                m_data = win_a ? a_data : b_data;
                m_pos  = win_a ? a_pos  : b_pos;
                m_wr   = (m_pos != 2'd3);
                m_completing = 8'b1 << m_sel;
                m_favour_b = win_a;
            end else begin
                m_wr = 1'b0;
            end
        end
        checkOutput("rd_write", rd_write, m_wr);
        checkOutput("rd_select", rd_select, m_sel);
        checkOutput("rd_in", rd_in, m_data);
        checkOutput("rd_pos", rd_pos, m_pos);
        checkOutput("pending", pending, m_pend);
    endtask

    task automatic idleInputs();
        rst_n = 1'b1; rf_en = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; resv_valid = 1'b0;
    endtask

    initial begin
        a_sel = 0; a_data = 0; a_pos = 0; b_sel = 0; b_data = 0; b_pos = 0;
        resv_sel = 0;
        idleInputs();
        rst_n = 1'b0;
        m_wr = 0; m_sel = 0; m_data = 0; m_pos = 0;
        m_favour_b = 0; m_pend = 0; m_completing = 0;

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_write", rd_write, 1'b0);
        checkOutput("rst_select", rd_select, 3'd0);
        checkOutput("rst_in", rd_in, 16'h0000);
        checkOutput("rst_pos", rd_pos, 2'd0);
        checkOutput("rst_pending", pending, 8'h00);

        // A alone writes r3
        idleInputs();
        a_valid = 1; a_sel = 3; a_data = 16'hBEEF; a_pos = 0;
        applyStimulus();
        checkOutput("tp1_a_ready", seen_a_ready, 1'b1);
        checkOutput("tp1_write", rd_write, 1'b1);
        checkOutput("tp1_select", rd_select, 3'd3);
        checkOutput("tp1_in", rd_in, 16'hBEEF);
        a_valid = 0;
        applyStimulus();
        checkOutput("tp1_write_off", rd_write, 1'b0);
        checkOutput("tp1_in_hold", rd_in, 16'hBEEF);

        // Contention alternates starting from A after reset
        rst_n = 0;
        applyStimulus();
        idleInputs();
        a_valid = 1; a_sel = 1; a_data = 16'hAAAA; a_pos = 0;
        b_valid = 1; b_sel = 2; b_data = 16'hBBBB; b_pos = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput($sformatf("tp2_grant%0d", i), {seen_a_ready, seen_b_ready},
                        (i % 2 == 0) ? 2'b10 : 2'b01);
            checkOutput($sformatf("tp2_write%0d", i), rd_write, 1'b1);
            checkOutput($sformatf("tp2_in%0d", i), rd_in,
                        (i % 2 == 0) ? 16'hAAAA : 16'hBBBB);
        end

        // Register file disabled stalls the request
        idleInputs();
        rf_en = 0;
        a_valid = 1; a_sel = 4; a_data = 16'h1234; a_pos = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("tp3_stall_ready%0d", i), seen_a_ready, 1'b0);
            checkOutput($sformatf("tp3_stall_write%0d", i), rd_write, 1'b0);
        end
        rf_en = 1;
        applyStimulus();
        checkOutput("tp3_ready", seen_a_ready, 1'b1);
        checkOutput("tp3_write", rd_write, 1'b1);
        checkOutput("tp3_in", rd_in, 16'h1234);

        // Byte position and no-op position on B
        idleInputs();
        b_valid = 1; b_sel = 6; b_data = 16'h12CD; b_pos = 2;
        applyStimulus();
        checkOutput("tp4_b_ready", seen_b_ready, 1'b1);
        checkOutput("tp4_pos", rd_pos, 2'd2);
        checkOutput("tp4_write", rd_write, 1'b1);
        b_sel = 7; b_data = 16'h5555; b_pos = 3;
        applyStimulus();
        checkOutput("tp4_nop_ready", seen_b_ready, 1'b1);
        checkOutput("tp4_nop_write", rd_write, 1'b0);

        // Scoreboard: reserve r5, write r5, then reserve on the clearing edge
        idleInputs();
        resv_valid = 1; resv_sel = 5;
        applyStimulus();
        resv_valid = 0;
        checkOutput("tp5_reserved", pending, SB ? 8'h20 : 8'h00);
        a_valid = 1; a_sel = 5; a_data = 16'h0F0F; a_pos = 0;
        applyStimulus();
        a_valid = 0;
        checkOutput("tp5_writing", pending, SB ? 8'h20 : 8'h00);
        applyStimulus();
        checkOutput("tp5_cleared", pending, 8'h00);
        resv_valid = 1;
        applyStimulus();
        resv_valid = 0;
        a_valid = 1;
        applyStimulus();
        a_valid = 0; resv_valid = 1;
        applyStimulus();
        resv_valid = 0;
        checkOutput("tp5_set_wins", pending, SB ? 8'h20 : 8'h00);
        applyStimulus();
        checkOutput("tp5_still_set", pending, SB ? 8'h20 : 8'h00);

        // Reset during the write cycle drops the write and clears state
        idleInputs();
        resv_valid = 1; resv_sel = 2;
        applyStimulus();
        resv_valid = 0;
        a_valid = 1; a_sel = 2; a_data = 16'h7777; a_pos = 1;
        applyStimulus();
        a_valid = 0; rst_n = 0;
        applyStimulus();
        checkOutput("tp6_write", rd_write, 1'b0);
        checkOutput("tp6_pending", pending, 8'h00);
        idleInputs();
        a_valid = 1; b_valid = 1;
        applyStimulus();
        checkOutput("tp6_grant", {seen_a_ready, seen_b_ready}, 2'b10);

        // Randomized traffic; each requester holds until accepted
        idleInputs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!(a_valid && !seen_a_ready)) begin
                a_valid = ($urandom_range(0, 9) < 6);
                a_sel = 3'($urandom_range(0, 7));
                a_data = 16'($urandom);
                a_pos = 2'($urandom_range(0, 3));
            end
            if (!(b_valid && !seen_b_ready)) begin
                b_valid = ($urandom_range(0, 9) < 6);
                b_sel = 3'($urandom_range(0, 7));
                b_data = 16'($urandom);
                b_pos = 2'($urandom_range(0, 3));
            end
            rf_en = ($urandom_range(0, 99) < 85);
            rst_n = ($urandom_range(0, 99) >= 2);
            resv_valid = ($urandom_range(0, 9) < 3);
            resv_sel = 3'($urandom_range(0, 7));
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
